// File: rtl/dcache_write_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------------------------+
// | dcache_write_buffer: posted line write-back FIFO; define WRITE_BUFFER_FORWARD_EN to serve   |
// | read hits from buffered lines.                                     Revision 1.0            |
// +--------------------------------------------------------------------------------------------+
module dcache_write_buffer #(
   parameter int ADDR_SIZE = 32,
   parameter int LINE_SIZE = 256,
   parameter int DEPTH     = 4
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 up_valid_i,
   input  logic                 up_write_i,
   input  logic [ADDR_SIZE-1:0] up_addr_i,
   input  logic [LINE_SIZE-1:0] up_wdata_i,
   output logic                 up_ready_o,
   output logic                 up_rvalid_o,
   output logic [LINE_SIZE-1:0] up_rdata_o,
   output logic                 mem_valid_o,
   output logic                 mem_write_o,
   output logic [ADDR_SIZE-1:0] mem_addr_o,
   output logic [LINE_SIZE-1:0] mem_wdata_o,
   input  logic                 mem_ready_i,
   input  logic                 mem_rvalid_i,
   input  logic [LINE_SIZE-1:0] mem_rdata_i
);

   localparam int OFF = $clog2(LINE_SIZE / 8);
   localparam int LA  = ADDR_SIZE - OFF;
   localparam int PW  = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DRAIN   = 3'd1,
      RD_REQ  = 3'd2,
      RD_WAIT = 3'd3,
      FWD     = 3'd4
   } state_t;

   state_t state, state_d;

   logic [LA-1:0]        addr_mem [DEPTH];
   logic [LINE_SIZE-1:0] data_mem [DEPTH];
   logic [PW-1:0]        head, tail;
   logic [PW:0]          count;

   logic [LA-1:0]        line_in;
   logic                 unused_offset;
   logic                 hit;
   logic [LINE_SIZE-1:0] hit_data;
   logic                 rd_ok;
   logic                 push, pop, rd_acc;

   logic                 mv_d, mw_d, rv_d;
   logic [ADDR_SIZE-1:0] ma_d;
   logic [LINE_SIZE-1:0] md_d, rd_d;

   assign line_in       = up_addr_i[ADDR_SIZE-1:OFF];
   assign unused_offset = ^up_addr_i[OFF-1:0];

`ifdef WRITE_BUFFER_FORWARD_EN
   logic [PW-1:0] idx;

   // Scan oldest to youngest so the last matching entry wins.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      idx      = head;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + PW'(k);
         if (((PW + 1)'(k) < count) && (addr_mem[idx] == line_in)) begin
            hit      = 1'b1;
            hit_data = data_mem[idx];
         end
      end
   end

   assign rd_ok = (count != FULL_CNT);
`else
   // Without forwarding the buffer is flushed before any read goes out.
   assign hit      = 1'b0;
   assign hit_data = '0;
   assign rd_ok    = (count == '0);
`endif

   assign up_ready_o = !reset_i && (up_write_i ? (count != FULL_CNT)
                                               : ((state == IDLE) && rd_ok));
   assign push   = up_valid_i && up_write_i && up_ready_o;
   assign rd_acc = up_valid_i && !up_write_i && up_ready_o;

   always_comb begin
      state_d = state;
      mv_d    = mem_valid_o;
      mw_d    = mem_write_o;
      ma_d    = mem_addr_o;
      md_d    = mem_wdata_o;
      rv_d    = 1'b0;
      rd_d    = up_rdata_o;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            if (rd_acc) begin
               if (hit) begin
                  state_d = FWD;
                  rv_d    = 1'b1;
                  rd_d    = hit_data;
               end else begin
                  state_d = RD_REQ;
                  mv_d    = 1'b1;
                  mw_d    = 1'b0;
                  ma_d    = {line_in, {OFF{1'b0}}};
               end
            end else if (count != '0) begin
               state_d = DRAIN;
               mv_d    = 1'b1;
               mw_d    = 1'b1;
               ma_d    = {addr_mem[head], {OFF{1'b0}}};
               md_d    = data_mem[head];
            end
         end
         DRAIN: begin
            if (mem_ready_i) begin
               pop     = 1'b1;
               mv_d    = 1'b0;
               state_d = IDLE;
            end
         end
         RD_REQ: begin
            if (mem_ready_i) begin
               mv_d    = 1'b0;
               state_d = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (mem_rvalid_i) begin
               rv_d    = 1'b1;
               rd_d    = mem_rdata_i;
               state_d = IDLE;
            end
         end
         FWD:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state       <= IDLE;
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         mem_valid_o <= 1'b0;
         mem_write_o <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         up_rvalid_o <= 1'b0;
         up_rdata_o  <= '0;
      end else begin
         state       <= state_d;
         mem_valid_o <= mv_d;
         mem_write_o <= mw_d;
         mem_addr_o  <= ma_d;
         mem_wdata_o <= md_d;
         up_rvalid_o <= rv_d;
         up_rdata_o  <= rd_d;
         if (push) tail <= tail + PW'(1);
         if (pop)  head <= head + PW'(1);
         count <= count + (PW + 1)'(push) - (PW + 1)'(pop);
      end
   end

   // Line storage needs no reset; occupancy is tracked by the pointers.
   always_ff @(posedge clk_i) begin
      if (push) begin
         addr_mem[tail] <= line_in;
         data_mem[tail] <= up_wdata_i;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dcache_write_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------------------------+
// | tb_dcache_write_buffer: directed scoreboard bench for dcache_write_buffer.  Revision 1.0   |
// +--------------------------------------------------------------------------------------------+
module tb_dcache_write_buffer;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [255:0] data;
   } mem_t;

   logic         clk_i = 1'b0;
   logic         reset_i = 1'b1;
   logic         up_valid_i = 1'b0;
   logic         up_write_i = 1'b0;
   logic [31:0]  up_addr_i = '0;
   logic [255:0] up_wdata_i = '0;
   logic         up_ready_o;
   logic         up_rvalid_o;
   logic [255:0] up_rdata_o;
   logic         mem_valid_o;
   logic         mem_write_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_wdata_o;
   logic         mem_ready_i = 1'b1;
   logic         mem_rvalid_i = 1'b0;
   logic [255:0] mem_rdata_i = '0;

   dcache_write_buffer #(.ADDR_SIZE(32), .LINE_SIZE(256), .DEPTH(4)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .up_valid_i(up_valid_i), .up_write_i(up_write_i), .up_addr_i(up_addr_i),
      .up_wdata_i(up_wdata_i), .up_ready_o(up_ready_o), .up_rvalid_o(up_rvalid_o),
      .up_rdata_o(up_rdata_o), .mem_valid_o(mem_valid_o), .mem_write_o(mem_write_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   int           ncmp = 0;
   int           nerr = 0;
   mem_t         exp_mem[$];
   logic [255:0] exp_rd[$];
   logic         last_acc = 1'b0;
   logic         auto_resp = 1'b1;
   logic         expect_resp = 1'b0;
   logic         rsp_seen = 1'b0;
   int           rsp_cnt = 0;
   logic [31:0]  rsp_addr = '0;

   function automatic logic [255:0] line(input logic [31:0] s);
      return {8{s}};
   endfunction

   function automatic logic [255:0] resp(input logic [31:0] a);
      return {8{a ^ 32'hA5A5_0000}};
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic exp_w(input logic [31:0] a, input logic [255:0] d);
      mem_t e;
      e.wr = 1'b1; e.addr = a & ~32'h1F; e.data = d;
      exp_mem.push_back(e);
   endtask

   task automatic exp_r(input logic [31:0] a);
      mem_t e;
      e.wr = 1'b0; e.addr = a & ~32'h1F; e.data = '0;
      exp_mem.push_back(e);
      exp_rd.push_back(resp(a & ~32'h1F));
   endtask

   // One clock: observe handshakes mid-cycle, then advance and run the memory responder.
   task automatic step();
      mem_t e;
      @(negedge clk_i);
      last_acc = up_valid_i && up_ready_o;
      if (mem_valid_o && mem_ready_i) begin
         ncmp++;
         assert (exp_mem.size() > 0) else begin
            nerr++;
            $error("FAIL mem_extra: observed wr=%0b addr=%0h expected no transaction", mem_write_o, mem_addr_o);
         end
         if (exp_mem.size() > 0) begin
            e = exp_mem.pop_front();
            chk("mem_wr", mem_write_o, e.wr);
            chk("mem_addr", mem_addr_o, e.addr);
            if (e.wr) chk("mem_wdata", mem_wdata_o, e.data);
         end
         if (!mem_write_o) begin
            expect_resp = 1'b1;
            rsp_addr    = mem_addr_o;
            if (auto_resp) rsp_cnt = 2;
         end
      end
      if (up_rvalid_o) begin
         ncmp++;
         assert (exp_rd.size() > 0) else begin
            nerr++;
            $error("FAIL rd_extra: observed %0h expected no read data", up_rdata_o);
         end
         if (exp_rd.size() > 0) chk("up_rdata", up_rdata_o, exp_rd.pop_front());
      end
      if (rsp_seen) begin
         chk("rvalid_lat", up_rvalid_o, 1'b1);
         rsp_seen = 1'b0;
      end
      if (mem_rvalid_i && expect_resp) begin
         rsp_seen    = 1'b1;
         expect_resp = 1'b0;
      end
      @(posedge clk_i);
      #1;
      mem_rvalid_i = 1'b0;
      if (rsp_cnt != 0) begin
         rsp_cnt--;
         if (rsp_cnt == 0) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = resp(rsp_addr);
         end
      end
   endtask

   task automatic up_req(input logic wr, input logic [31:0] a, input logic [255:0] d);
      up_valid_i = 1'b1; up_write_i = wr; up_addr_i = a; up_wdata_i = d;
      last_acc = 1'b0;
      for (int i = 0; i < 40 && !last_acc; i++) step();
      up_valid_i = 1'b0;
      chk($sformatf("accept_%0h", a), last_acc, 1'b1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100; i++) begin
         if (dut.count == 0 && !mem_valid_o && !expect_resp && !rsp_seen &&
             exp_mem.size() == 0 && exp_rd.size() == 0) break;
         step();
      end
      chk("idle_count", dut.count, 0);
      chk("idle_memq", exp_mem.size(), 0);
      chk("idle_rdq", exp_rd.size(), 0);
   endtask

   initial begin
      step(); step();
      chk("rst_mem_valid", mem_valid_o, 1'b0);
      chk("rst_up_ready", up_ready_o, 1'b0);
      chk("rst_up_rvalid", up_rvalid_o, 1'b0);
      chk("rst_count", dut.count, 0);
      reset_i = 1'b0;
      step();

      // Single write drains two cycles after acceptance.
      exp_w(32'h1000, line(32'hA000_0001));
      up_req(1'b1, 32'h1000, line(32'hA000_0001));
      step();
      chk("drain_valid", {mem_valid_o, mem_write_o, mem_addr_o}, {1'b1, 1'b1, 32'h1000});
      wait_idle();

      // Fill to full with downstream stalled, then drain in order.
      mem_ready_i = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         exp_w(32'h100 * i, line(32'hB000_0000 + i));
         up_req(1'b1, 32'h100 * i, line(32'hB000_0000 + i));
      end
      up_valid_i = 1'b1; up_write_i = 1'b1; up_addr_i = 32'h500; up_wdata_i = line(32'hB5);
      #1;
      chk("full_ready", up_ready_o, 1'b0);
      chk("full_count", dut.count, 4);
      step();
      up_valid_i = 1'b0;
      chk("full_no_accept", last_acc, 1'b0);
      mem_ready_i = 1'b1;
      wait_idle();

      // Two same-line writes land while a read miss is in flight; then read that line.
      exp_r(32'h2800);
      up_req(1'b0, 32'h2800, '0);
      exp_w(32'h2000, line(32'hA0A0_0002));
      up_req(1'b1, 32'h2000, line(32'hA0A0_0002));
      exp_w(32'h2000, line(32'hB0B0_0002));
      up_req(1'b1, 32'h2000, line(32'hB0B0_0002));
`ifdef WRITE_BUFFER_FORWARD_EN
      mem_ready_i = 1'b0;
      exp_rd.push_back(line(32'hB0B0_0002));
      up_req(1'b0, 32'h2004, '0);
      chk("hit_lat", {up_rvalid_o, up_rdata_o}, {1'b1, line(32'hB0B0_0002)});
      mem_ready_i = 1'b1;
`else
      exp_r(32'h2004);
      up_req(1'b0, 32'h2004, '0);
      chk("flush_then_read", {mem_valid_o, mem_write_o, mem_addr_o}, {1'b1, 1'b0, 32'h2000});
`endif
      wait_idle();

      // Read miss next to a buffered write to a different line.
`ifdef WRITE_BUFFER_FORWARD_EN
      exp_r(32'h3000);
      exp_w(32'h4000, line(32'hC000_0004));
`else
      exp_w(32'h4000, line(32'hC000_0004));
      exp_r(32'h3000);
`endif
      up_req(1'b1, 32'h4000, line(32'hC000_0004));
      up_req(1'b0, 32'h3000, '0);
      chk("miss_lat", {mem_valid_o, mem_write_o, mem_addr_o}, {1'b1, 1'b0, 32'h3000});
      wait_idle();

      // Reset while a read waits for data with two writes buffered.
      auto_resp = 1'b0;
      begin
         mem_t e;
         e.wr = 1'b0; e.addr = 32'h7000; e.data = '0;
         exp_mem.push_back(e);
      end
      up_req(1'b0, 32'h7000, '0);
      up_req(1'b1, 32'h8000, line(32'hD000_0008));
      up_req(1'b1, 32'h9000, line(32'hD000_0009));
      chk("pre_rst_count", dut.count, 2);
      #2;
      reset_i = 1'b1;
      #1;
      chk("arst_mem_valid", mem_valid_o, 1'b0);
      chk("arst_mem_addr", mem_addr_o, 32'h0);
      chk("arst_up_ready", up_ready_o, 1'b0);
      chk("arst_up_rdata", up_rdata_o, 256'h0);
      chk("arst_count", dut.count, 0);
      step();
      reset_i     = 1'b0;
      expect_resp = 1'b0;
      rsp_seen    = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = line(32'hDEAD_BEEF);
      step();
      chk("late_rvalid", up_rvalid_o, 1'b0);
      chk("late_rdata", up_rdata_o, 256'h0);
      step(); step();
      chk("post_rst_mem_valid", mem_valid_o, 1'b0);
      chk("post_rst_count", dut.count, 0);
      chk("final_memq", exp_mem.size(), 0);
      chk("final_rdq", exp_rd.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
`default_nettype wire
